// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Purpose : Types shared by the pipeline hazard controller and its scoreboard.
//           Holds the forwarding select encoding, the controller FSM states,
//           the scoreboard entry layout and a small forwarding priority helper.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Width of the rd field stored in each scoreboard entry. Must equal the
  // XREG_W parameter of the controller.
  localparam int XREG_W_PKG = 5;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } pctrl_state_t;

  typedef struct packed {
    logic                  valid;
    logic [XREG_W_PKG-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } sb_entry_t;

  // hit[0] = producer currently in EX, hit[1] = producer currently in MEM.
  // The EX producer is younger, so it wins when both match.
  function automatic fwd_sel_t fwd_pick(input logic [1:0] hit);
    if (hit[0]) begin
      return FWD_EXMEM;
    end else if (hit[1]) begin
      return FWD_MEMWB;
    end
    return FWD_REG;
  endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : pipe_scoreboard
// Purpose : Three-entry EX/MEM/WB shift register of in-flight destination
//           registers plus the per-source match logic.
// Ports   : clk, reset          - clock, synchronous active-high reset
//           advance             - normal shift (WB<=MEM, MEM<=EX, EX<=new)
//                                 when low: EX holds, MEM drains, WB<=MEM
//           ex_load             - on advance, capture the ID fields into EX
//                                 (otherwise EX receives a bubble)
//           id_rd/regwrite/memread - ID destination info
//           id_rs1/rs2, id_use_rs1/rs2 - ID sources and their use bits
//           rs1_hit/rs2_hit     - [0]=EX, [1]=MEM, [2]=WB eligible match
//           ex_memread          - EX entry is a valid load
// Revision: 1.0 - initial release
// ============================================================================
module pipe_scoreboard
  import riscv_pkg::*;
#(
  parameter int XREG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              ex_load,
  input  logic [XREG_W-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [XREG_W-1:0] id_rs1,
  input  logic [XREG_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  output logic [2:0]        rs1_hit,
  output logic [2:0]        rs2_hit,
  output logic              ex_memread
);

  localparam int SB_EX  = 0;
  localparam int SB_MEM = 1;
  localparam int SB_WB  = 2;

  sb_entry_t sb_q [3];
  sb_entry_t sb_d [3];

  always_comb begin
    sb_d[SB_EX]  = sb_q[SB_EX];
    sb_d[SB_MEM] = '0;
    sb_d[SB_WB]  = sb_q[SB_MEM];
    if (advance) begin
      sb_d[SB_MEM] = sb_q[SB_EX];
      sb_d[SB_EX]  = '0;
      if (ex_load) begin
        sb_d[SB_EX].valid    = 1'b1;
        sb_d[SB_EX].rd       = id_rd;
        sb_d[SB_EX].regwrite = id_regwrite;
        sb_d[SB_EX].memread  = id_memread;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  // x0 writes are architecturally discarded, so they never create hazards.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_hit
      logic w_elig;
      assign w_elig     = sb_q[g].valid && sb_q[g].regwrite && (sb_q[g].rd != '0);
      assign rs1_hit[g] = id_use_rs1 && w_elig && (sb_q[g].rd == id_rs1);
      assign rs2_hit[g] = id_use_rs2 && w_elig && (sb_q[g].rd == id_rs2);
    end
  endgenerate

  assign ex_memread = sb_q[SB_EX].valid && sb_q[SB_EX].memread;

endmodule : pipe_scoreboard
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl
// Purpose : Hazard controller for the 5-stage core: load-use stall, taken-
//           branch flush, registered EX forwarding selects and the RUN/MC_WAIT
//           sequencer for multi-cycle EX operations.
// Ports   : clk, reset                  - clock, synchronous active-high reset
//           id_*                        - instruction currently in decode
//           ex_branch_taken             - branch resolved taken in EX
//           mc_done                     - multi-cycle result pulse
//           stall, pc_write, if_id_write- decode bubble / fetch enables
//           flush_if_id, flush_id_ex    - squash pipeline registers
//           fwd_a, fwd_b                - 0 regfile, 1 EX/MEM, 2 MEM/WB
//           mc_busy                     - multi-cycle op outstanding
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int XREG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XREG_W-1:0] id_rs1,
  input  logic [XREG_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XREG_W-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_multicycle,
  input  logic              ex_branch_taken,
  input  logic              mc_done,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mc_busy
);

  pctrl_state_t state_q, state_d;
  fwd_sel_t     fwd_a_q, fwd_a_d;
  fwd_sel_t     fwd_b_q, fwd_b_d;

  logic [2:0] w_rs1_hit;
  logic [2:0] w_rs2_hit;
  logic       w_ex_memread;
  logic       w_run;
  logic       w_flush;
  logic       w_load_use;
  logic       w_ex_load;
  logic       w_unused_wb_hit;

  pipe_scoreboard #(
    .XREG_W (XREG_W)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .advance     (w_run),
    .ex_load     (w_ex_load),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .rs1_hit     (w_rs1_hit),
    .rs2_hit     (w_rs2_hit),
    .ex_memread  (w_ex_memread)
  );

  // WB producers are covered by the write-through register file.
  assign w_unused_wb_hit = w_rs1_hit[2] ^ w_rs2_hit[2];

  always_comb begin
    w_run       = (state_q == RUN);
    // A multi-cycle op in EX is never a branch, so a taken flag seen in
    // MC_WAIT is stale and dropped.
    w_flush     = w_run && ex_branch_taken;
    w_load_use  = w_run && id_valid && w_ex_memread && (w_rs1_hit[0] || w_rs2_hit[0]);
    stall       = !w_run || (w_load_use && !w_flush);
    pc_write    = !stall;
    if_id_write = !stall;
    flush_if_id = w_flush;
    flush_id_ex = w_flush;
    mc_busy     = !w_run;
    w_ex_load   = id_valid && !stall && !w_flush;

    state_d = state_q;
    case (state_q)
      RUN:     if (w_ex_load && id_multicycle) state_d = MC_WAIT;
      MC_WAIT: if (mc_done) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Selects follow the instruction into EX; a bubble entering EX gets the
    // regfile select, and in MC_WAIT the held EX instruction keeps its own.
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (w_run) begin
      fwd_a_d = w_ex_load ? fwd_pick(w_rs1_hit[1:0]) : FWD_REG;
      fwd_b_d = w_ex_load ? fwd_pick(w_rs2_hit[1:0]) : FWD_REG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      state_q <= state_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_ctrl
// Purpose : Directed test-plan sequences followed by randomized traffic for
//           pipeline_ctrl. A reference model of in-flight instructions
//           predicts each cycle's outputs into a queue; a monitor on the
//           falling edge pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0, id_multicycle = 1'b0;
  logic       ex_branch_taken = 1'b0, mc_done = 1'b0;
  logic       stall, pc_write, if_id_write, flush_if_id, flush_id_ex, mc_busy;
  logic [1:0] fwd_a, fwd_b;

  pipeline_ctrl #(.XREG_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_multicycle   (id_multicycle),
    .ex_branch_taken (ex_branch_taken),
    .mc_done         (mc_done),
    .stall           (stall),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mc_busy         (mc_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall, pc_write, if_id_write, flush_if_id, flush_id_ex, mc_busy;
    logic [1:0] fwd_a, fwd_b;
  } exp_t;

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } slot_t;

  exp_t  exp_q[$];
  slot_t pipe[3];          // 0 = in EX, 1 = in MEM, 2 = in WB
  bit    m_known = 0;
  bit    m_waiting = 0;    // a multi-cycle op occupies EX
  bit    m_stall = 0;      // decode was told to hold its instruction
  int    m_fwd_a = 0, m_fwd_b = 0;
  int    checks = 0, failures = 0;
  int    cycle = 0;

  function automatic bit producer(int k, int rs);
    return pipe[k].v && pipe[k].wr && pipe[k].rd != 0 && pipe[k].rd == rs;
  endfunction

  // Distance to the youngest in-flight producer of rs: 1 = EX, 2 = MEM.
  function automatic int youngest(int rs, bit used);
    if (!used) return 0;
    for (int k = 0; k < 2; k++) if (producer(k, rs)) return k + 1;
    return 0;
  endfunction

  task automatic cyc(input bit rst, input bit v, input int rs1, input int rs2,
                     input bit u1, input bit u2, input int rd, input bit wr,
                     input bit ld, input bit mc, input bit br, input bit done);
    bit   flush, lu, stl, enter;
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_valid = v; id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0];
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = rd[4:0]; id_regwrite = wr;
    id_memread = ld; id_multicycle = mc; ex_branch_taken = br; mc_done = done;
    cycle++;

    flush = !m_waiting && br;
    lu    = !m_waiting && v && pipe[0].ld &&
            ((u1 && producer(0, rs1)) || (u2 && producer(0, rs2)));
    stl   = m_waiting || (lu && !flush);
    if (m_known) begin
      e.stall = stl; e.pc_write = !stl; e.if_id_write = !stl;
      e.flush_if_id = flush; e.flush_id_ex = flush; e.mc_busy = m_waiting;
      e.fwd_a = 2'(m_fwd_a); e.fwd_b = 2'(m_fwd_b);
      exp_q.push_back(e);
    end
    m_stall = stl;

    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
      m_waiting = 0; m_fwd_a = 0; m_fwd_b = 0; m_known = 1;
    end else if (!m_waiting) begin
      enter   = v && !stl && !flush;
      m_fwd_a = enter ? youngest(rs1, u1) : 0;
      m_fwd_b = enter ? youngest(rs2, u2) : 0;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = enter ? '{1, rd, wr, ld} : '{0, 0, 0, 0};
      if (enter && mc) m_waiting = 1;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = '{0, 0, 0, 0};
      if (done) m_waiting = 0;
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall",       {1'b0, stall},       {1'b0, e.stall});
      chk("pc_write",    {1'b0, pc_write},    {1'b0, e.pc_write});
      chk("if_id_write", {1'b0, if_id_write}, {1'b0, e.if_id_write});
      chk("flush_if_id", {1'b0, flush_if_id}, {1'b0, e.flush_if_id});
      chk("flush_id_ex", {1'b0, flush_id_ex}, {1'b0, e.flush_id_ex});
      chk("mc_busy",     {1'b0, mc_busy},     {1'b0, e.mc_busy});
      chk("fwd_a",       fwd_a,               e.fwd_a);
      chk("fwd_b",       fwd_b,               e.fwd_b);
    end
  end

  initial begin
    bit v, u1, u2, wr, ld, mc;
    int rs1, rs2, rd;
    // Reset for two cycles.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(1);
    // ld x5 ; add x6,x5,x7 (held once by the load-use bubble)
    cyc(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    cyc(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0);
    cyc(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0);
    nop(3);
    // add x5 ; sub x8,x5,x5
    cyc(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
    cyc(0, 1, 5, 5, 1, 1, 8, 1, 0, 0, 0, 0);
    nop(2);
    // add x5 ; add x9,x1,x2 ; sub x8,x5,x5
    cyc(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 0);
    cyc(0, 1, 5, 5, 1, 1, 8, 1, 0, 0, 0, 0);
    nop(3);
    // ld x0 ; use of x0
    cyc(0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0);
    nop(2);
    // ld x3 ; rs1=3 but not read
    cyc(0, 1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0);
    cyc(0, 1, 3, 4, 0, 1, 6, 1, 0, 0, 0, 0);
    nop(2);
    // add x4 ; mul x10 ; add x11,x10,x4 held for 4 MC_WAIT cycles
    cyc(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 2, 1, 1, 10, 1, 0, 1, 0, 0);
    cyc(0, 1, 10, 4, 1, 1, 11, 1, 0, 0, 0, 0);
    cyc(0, 1, 10, 4, 1, 1, 11, 1, 0, 0, 0, 0);
    cyc(0, 1, 10, 4, 1, 1, 11, 1, 0, 0, 0, 0);
    cyc(0, 1, 10, 4, 1, 1, 11, 1, 0, 0, 0, 1);
    cyc(0, 1, 10, 4, 1, 1, 11, 1, 0, 0, 0, 0);
    nop(3);
    // ld x5 ; add x6,x5 while a branch resolves taken
    cyc(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    cyc(0, 1, 5, 7, 1, 1, 6, 1, 0, 0, 1, 0);
    nop(2);
    // mul then reset while waiting
    cyc(0, 1, 1, 2, 1, 1, 12, 1, 0, 1, 0, 0);
    cyc(0, 1, 12, 0, 1, 0, 13, 1, 0, 0, 0, 0);
    cyc(0, 1, 12, 0, 1, 0, 13, 1, 0, 0, 1, 0);
    cyc(1, 1, 12, 0, 1, 0, 13, 1, 0, 0, 0, 0);
    nop(2);

    // Randomized traffic; decode holds its instruction whenever stalled.
    v = 0; u1 = 0; u2 = 0; wr = 0; ld = 0; mc = 0; rs1 = 0; rs2 = 0; rd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!m_stall) begin
        v   = ($urandom % 8) != 0;
        rs1 = $urandom % 8;
        rs2 = $urandom % 8;
        rd  = $urandom % 8;
        u1  = v && ($urandom % 4 != 0);
        u2  = v && ($urandom % 2 != 0);
        wr  = v && ($urandom % 4 != 0);
        ld  = wr && ($urandom % 3 == 0);
        mc  = v && !ld && ($urandom % 8 == 0);
      end
      cyc(($urandom % 150) == 0, v, rs1, rs2, u1, u2, rd, wr, ld, mc,
          ($urandom % 10) == 0, ($urandom % 4) == 0);
    end
    nop(1);

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipeline_ctrl
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline hazard controller for the 5-stage RV64 core. It sits beside the decode stage and tracks in-flight destination registers in a small EX/MEM/WB scoreboard. It generates the `stall` consumed by decode's control unit, the PC/IF-ID write enables, IF/ID and ID/EX flushes on taken branches, and registered forwarding selects for the EX operand muxes. It also sequences multi-cycle EX operations (mul/div) through a two-state FSM.

## Interface
Parameters:
- `XREG_W`, 5, register index width

Ports:
- `clk`  in  1  core clock; single clock domain
- `reset`  in  1  synchronous, active-high
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`  in  XREG_W  ID source indices
- `id_use_rs1`, `id_use_rs2`  in  1  source actually read
- `id_rd`  in  XREG_W  ID destination
- `id_regwrite`, `id_memread`, `id_multicycle`  in  1  ID control bits
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX
- `mc_done`  in  1  multi-cycle unit result valid (1-cycle pulse)
- `stall`  out  1  to decode; forces control outputs to zero (bubble)
- `pc_write`, `if_id_write`  out  1  fetch/IF-ID register enables
- `flush_if_id`, `flush_id_ex`  out  1  squash those pipeline registers
- `fwd_a`, `fwd_b`  out  2  EX operand select: 0 regfile, 1 EX/MEM, 2 MEM/WB
- `mc_busy`  out  1  FSM in MC_WAIT

## Operation
- Scoreboard: three entries (EX, MEM, WB), each {valid, rd, regwrite, memread}.
- An entry is hazard/forward-eligible only when valid, regwrite is set, and rd != 0.
- Advance on every cycle not held by MC_WAIT:
  - WB <= MEM, MEM <= EX.
  - EX <= ID fields if id_valid && !stall && !ex_branch_taken; otherwise EX <= bubble (valid=0).
- In MC_WAIT: EX and ID hold; MEM shifts into WB and MEM becomes a bubble.
- Load-use hazard: EX entry is eligible with memread=1, and its rd matches an ID source whose use bit is set. Result: stall=1, pc_write=0, if_id_write=0, and EX receives a bubble.
- Forward selects are computed in ID and registered so they are valid with the instruction in EX:
  - fwd_x=1 if the current EX entry matches the source.
  - Otherwise fwd_x=2 if the MEM entry matches.
  - Otherwise 0. Youngest producer wins.
  - In a load-use stall cycle, selects are recomputed next cycle.
- FSM states RUN and MC_WAIT:
  - RUN -> MC_WAIT when an id_multicycle instruction enters EX.
  - MC_WAIT -> RUN on mc_done.
  - In MC_WAIT: stall=1, pc_write=0, if_id_write=0, mc_busy=1.
- Taken branch (RUN only): flush_if_id=1, flush_id_ex=1, pc_write=1; EX receives a bubble. Flush has priority over load-use stall in the same cycle.
- ex_branch_taken is ignored in MC_WAIT, because a multi-cycle op is never a branch.

## Timing
- Reset values: all entries invalid, FSM=RUN, fwd_a=fwd_b=0, stall=0, pc_write=1, if_id_write=1, both flushes=0, mc_busy=0.
- stall, pc_write, if_id_write, flushes: combinational from ID inputs, scoreboard, and FSM, within the same cycle.
- fwd_a/fwd_b: registered; updated 1 cycle after the ID compare.
- Load-use: exactly one bubble cycle. The dependent instruction reaches EX with fwd=2.
- Multi-cycle: stall is asserted from the cycle after issue through the mc_done cycle inclusive. It deasserts the cycle after mc_done.
  - An mc_done arriving in RUN is ignored.
  - mc_done in the same cycle MC_WAIT is entered is not possible (minimum 1-cycle latency).
- Reset mid-MC_WAIT or mid-stall: return to RUN with all entries invalid on the next edge.

## Structure
- Shared package `riscv_pkg` holds:
  - `fwd_sel_t` enum (FWD_REG, FWD_EXMEM, FWD_MEMWB)
  - `pctrl_state_t` enum (RUN, MC_WAIT)
  - `sb_entry_t` struct
- One sub-module, `pipe_scoreboard`, owns the three-entry shift register and the match logic. It outputs per-source hit vectors.
- The FSM and output logic live in `pipeline_ctrl`.

## Test plan
- Reset: assert reset 2 cycles -> stall=0, pc_write=1, fwd_a=fwd_b=0, mc_busy=0.
- `ld x5` followed by `add x6,x5,x7` -> exactly one cycle with stall=1, pc_write=0; add enters EX with fwd_a=2, fwd_b=0.
- `add x5,..` then `sub x8,x5,x5` -> no stall; fwd_a=fwd_b=1. With one independent instruction between them -> fwd_a=fwd_b=2.
- `ld x0` then a use of x0 -> no stall, fwd=0. A load to x3 with id_use_rs1=0 and rs1=3 -> no stall.
- `mul` issue, mc_done after 4 cycles -> mc_busy high for 4 cycles, stall deasserts the following cycle; MEM/WB entries drain.
- ex_branch_taken coincident with a load-use condition -> flush_if_id=flush_id_ex=1, pc_write=1, stall=0. A subsequent reset during MC_WAIT -> RUN on the next edge.
